// File: rtl/delta_capture_fifo_if.sv
// Host/upstream bundle for delta_capture_fifo. Signal suffixes are from the FIFO's point of view:
// the slave modport is the FIFO, the master modport is the upstream register plus CSR host.
interface delta_capture_fifo_if #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned Depth        = 8,
    parameter int unsigned TsWidth      = 16,
    parameter int unsigned DropCntWidth = 8
);
    localparam int unsigned LvlWidth = $clog2(Depth + 1);

    logic                    value_change_i;
    logic [DataWidth-1:0]    value_in_i;
    logic                    pop_i;
    logic                    ovf_clr_i;
    logic                    read_event_o;
    logic [DataWidth-1:0]    dout_value_o;
    logic [TsWidth-1:0]      dout_ts_o;
    logic                    empty_o;
    logic                    full_o;
    logic [LvlWidth-1:0]     level_o;
    logic                    overflow_o;
    logic [DropCntWidth-1:0] drop_count_o;
    logic                    irq_o;

    modport slave (
        input  value_change_i, value_in_i, pop_i, ovf_clr_i,
        output read_event_o, dout_value_o, dout_ts_o, empty_o, full_o, level_o,
        output overflow_o, drop_count_o, irq_o
    );

    modport master (
        output value_change_i, value_in_i, pop_i, ovf_clr_i,
        input  read_event_o, dout_value_o, dout_ts_o, empty_o, full_o, level_o,
        input  overflow_o, drop_count_o, irq_o
    );
endinterface

// File: rtl/delta_capture_fifo.sv
// Captures timestamped snapshots of an upstream delta register into a show-ahead FIFO and acks
// each change with a one-cycle READ_EVENT; tracks dropped changes and raises a level/overflow IRQ.
module delta_capture_fifo #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned Depth        = 8,
    parameter int unsigned TsWidth      = 16,
    parameter bit          DropOnFull   = 1'b1,
    parameter int unsigned IrqThreshold = 1,
    parameter int unsigned DropCntWidth = 8
) (
    input logic                clk,
    input logic                rst,
    delta_capture_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth + 1);
    localparam int unsigned EntW = TsWidth + DataWidth;
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);
    localparam logic [LvlW-1:0] IrqLvl   = LvlW'(IrqThreshold);

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e                  state_q, state_d;
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]         level_q, level_d;
    logic [TsWidth-1:0]      ts_q;
    logic                    overflow_q, overflow_d;
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic                    irq_q;
    logic [EntW-1:0]         mem_q [Depth];

    logic pop_ok, space_ok, change_seen, push, drop;

    always_comb begin
        pop_ok      = bus.pop_i && (level_q != '0);
        // A same-cycle pop frees the slot, so a full FIFO can still accept a push.
        space_ok    = (level_q != DepthLvl) || pop_ok;
        change_seen = (state_q == StIdle) && bus.value_change_i;
        push        = change_seen && space_ok;
        drop        = change_seen && !space_ok && DropOnFull;
        state_d     = (push || drop) ? StAck : StIdle;
        level_d     = level_q + LvlW'(push) - LvlW'(pop_ok);

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.ovf_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        // Drop applied after the clear so a coincident drop leaves the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_cnt_d)) drop_cnt_d = drop_cnt_d + DropCntWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TsWidth'(1);
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            irq_q      <= (level_d >= IrqLvl) || overflow_d;
            if (push)   wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage needs no reset: contents are unobservable while EMPTY.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ts_q, bus.value_in_i};
    end

    assign bus.read_event_o = (state_q == StAck);
    assign bus.dout_value_o = mem_q[rd_ptr_q][DataWidth-1:0];
    assign bus.dout_ts_o    = mem_q[rd_ptr_q][EntW-1 -: TsWidth];
    assign bus.empty_o      = (level_q == '0);
    assign bus.full_o       = (level_q == DepthLvl);
    assign bus.level_o      = level_q;
    assign bus.overflow_o   = overflow_q;
    assign bus.drop_count_o = drop_cnt_q;
    assign bus.irq_o        = irq_q;
endmodule
